// File: rtl/lifo_stream_reader.sv
// lifo_stream_reader: pops words from sc_lifo on start, re-times the LIFO's
// registered read data through a 4-entry buffer and emits them as a
// valid/ready packet, tagging the final word with m_last.
module lifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  lifo_rd,
    input  logic [DATA_WIDTH-1:0] lifo_data,
    input  logic                  lifo_empty,
    input  logic [LEN_WIDTH-1:0]  lifo_words,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [LEN_WIDTH-1:0]  words_sent
);

    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_mode_all;
    logic                  r_first;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  r_buf_last;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_buf_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_words_sent;

    logic                  w_issue;
    logic                  w_tag;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_occupancy;
    logic [CNT_W-1:0]      w_cnt_next;

    // Pop decision: a buffer slot is reserved for every word already in flight
    always_comb begin
        w_occupancy = r_buf_cnt + CNT_W'(r_inflight);
        w_issue     = (r_state == S_DRAIN) && !lifo_empty
                      && (w_occupancy < CNT_W'(BUF_DEPTH))
                      && (r_mode_all || (r_remaining != '0));
        w_tag       = r_mode_all ? (lifo_words == LEN_WIDTH'(1))
                                 : (r_remaining == LEN_WIDTH'(1));
        w_push      = r_inflight;
        w_pop       = (r_buf_cnt != '0) && m_ready;
        w_cnt_next  = r_buf_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Control FSM, capture buffer and beat counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_mode_all      <= 1'b0;
            r_first         <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
            end
            r_buf_last      <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_buf_cnt       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_words_sent    <= '0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_tag;

            if (w_push) begin
                r_buf_data[r_wr_ptr] <= lifo_data;
                r_buf_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (r_words_sent != '1) begin
                    r_words_sent <= r_words_sent + LEN_WIDTH'(1);
                end
            end
            r_buf_cnt <= w_cnt_next;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining  <= len;
                        r_mode_all   <= (len == '0);
                        r_first      <= 1'b1;
                        r_words_sent <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_first <= 1'b0;
                    if (w_issue) begin
                        if (!r_mode_all) begin
                            r_remaining <= r_remaining - LEN_WIDTH'(1);
                        end
                        if (w_tag) begin
                            r_state <= S_FLUSH;
                        end
                    end else if (r_mode_all && r_first && lifo_empty) begin
                        // Nothing to drain: finish without emitting a beat
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (!r_inflight && (w_cnt_next == '0)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign lifo_rd    = w_issue;
    assign m_valid    = (r_buf_cnt != '0);
    assign m_data     = r_buf_data[r_rd_ptr];
    assign m_last     = r_buf_last[r_rd_ptr];
    assign busy       = r_busy;
    assign done       = r_done;
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_lifo_stream_reader.sv
// Self-checking bench for lifo_stream_reader with a behavioural LIFO model.
module tb_lifo_stream_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          lifo_rd;
    logic [DW-1:0] lifo_data = '0;
    logic          lifo_empty;
    logic [LW-1:0] lifo_words;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [LW-1:0] words_sent;

    int errors = 0;
    int checks = 0;

    lifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .busy(busy), .done(done), .lifo_rd(lifo_rd),
        .lifo_data(lifo_data), .lifo_empty(lifo_empty), .lifo_words(lifo_words),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // Behavioural sc_lifo: registered read data, push+pop returns data_in
    logic [DW-1:0] mem [0:63];
    int            sp = 0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;

    always @(posedge clk) begin
        if (lifo_rd && sp > 0) begin
            if (push) begin
                lifo_data <= push_data;
            end else begin
                lifo_data <= mem[sp-1];
                sp <= sp - 1;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp <= sp + 1;
        end
    end
    assign lifo_empty = (sp == 0);
    assign lifo_words = LW'(sp);

    // Observation state filled by collect()
    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] push_q [$];
    int first_valid_k, done_k, rd_cnt, rd_early, rd_empty_cnt, hold_viol, valid_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push = 1'b1;
        push_data = d;
        tick();
        push = 1'b0;
    endtask

    // Expected packet: most recently pushed word first
    task automatic snap_expect(input int take);
        exp_q.delete();
        for (int i = 0; i < take; i++) exp_q.push_back(mem[sp-1-i]);
    endtask

    task automatic do_start(input logic [LW-1:0] l);
        start = 1'b1;
        len = l;
        tick();
        start = 1'b0;
    endtask

    // Runs from cycle S+1 (k=1); returns on done, stop_beats, or cycle budget
    task automatic collect(input int max_cyc, input int ready_mode,
                           input int stop_beats, input int push_k);
        logic pv, pr;
        logic [DW-1:0] pd;
        got_data.delete();
        got_last.delete();
        first_valid_k = -1; done_k = -1; rd_cnt = 0; rd_early = 0;
        rd_empty_cnt = 0; hold_viol = 0; valid_cnt = 0;
        pv = 1'b0; pr = 1'b1; pd = '0;
        for (int k = 1; k <= max_cyc; k++) begin
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k > 10);
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
            if (push_k > 0 && k >= push_k && push_q.size() > 0) begin
                push = 1'b1;
                push_data = push_q.pop_front();
            end else begin
                push = 1'b0;
            end
            if (m_valid) valid_cnt++;
            if (m_valid && first_valid_k < 0) first_valid_k = k;
            if (pv && !pr && (!m_valid || m_data !== pd)) hold_viol++;
            if (lifo_rd) rd_cnt++;
            if (lifo_rd && k <= 10) rd_early++;
            if (lifo_rd && lifo_empty) rd_empty_cnt++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
            end
            if (done) begin
                done_k = k;
                push = 1'b0;
                return;
            end
            pv = m_valid; pr = m_ready; pd = m_data;
            if (stop_beats > 0 && got_data.size() >= stop_beats) begin
                tick();
                push = 1'b0;
                return;
            end
            tick();
        end
        push = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, done, lifo_rd, m_valid, m_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/rd/valid/last=%b expected 00000",
                     {busy, done, lifo_rd, m_valid, m_last});
        end
        checks++;
        if (m_data !== '0 || words_sent !== '0) begin
            errors++;
            $display("FAIL reset_data: m_data=%h words_sent=%0d expected 0/0", m_data, words_sent);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b m_valid=%b expected 0/0", busy, m_valid);
        end
    endtask

    task automatic test_drain_all();
        for (int i = 1; i <= 5; i++) push_word(DW'(i));
        snap_expect(5);
        do_start('0);
        collect(40, 0, 0, 0);
        checks++;
        if (got_data.size() !== 5) begin
            errors++;
            $display("FAIL drain_all_count: got %0d beats expected 5", got_data.size());
        end
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== DW'(5 - i) || got_last[i] !== (i == 4)) begin
                errors++;
                $display("FAIL drain_all_beat%0d: got %h last=%b expected %h last=%b",
                         i, got_data[i], got_last[i], DW'(5 - i), (i == 4));
            end
        end
        checks++;
        if (first_valid_k !== 3) begin
            errors++;
            $display("FAIL drain_all_latency: first m_valid at S+%0d expected S+3", first_valid_k);
        end
        checks++;
        if (done_k !== 8) begin
            errors++;
            $display("FAIL drain_all_done: done at S+%0d expected S+8", done_k);
        end
        checks++;
        if (words_sent !== LW'(5) || lifo_empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_all_end: words_sent=%0d empty=%b busy=%b expected 5/1/0",
                     words_sent, lifo_empty, busy);
        end
    endtask

    task automatic test_len();
        for (int i = 0; i < 5; i++) push_word($urandom);
        snap_expect(3);
        do_start(LW'(3));
        collect(40, 0, 0, 0);
        checks++;
        if (got_data.size() !== 3 || done_k < 0) begin
            errors++;
            $display("FAIL len_count: got %0d beats done_k=%0d expected 3 beats with done",
                     got_data.size(), done_k);
        end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL len_beat%0d: got %h last=%b expected %h last=%b",
                         i, got_data[i], got_last[i], exp_q[i], (i == 2));
            end
        end
        checks++;
        if (words_sent !== LW'(3) || lifo_words !== LW'(2)) begin
            errors++;
            $display("FAIL len_end: words_sent=%0d lifo_words=%0d expected 3/2", words_sent, lifo_words);
        end
        // Drain what is left so later tests start from an empty LIFO
        snap_expect(2);
        do_start('0);
        collect(40, 0, 0, 0);
        checks++;
        if (got_data.size() !== 2 || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1]
            || got_last[1] !== 1'b1 || got_last[0] !== 1'b0) begin
            errors++;
            $display("FAIL len_rest: got %0d beats expected %h,%h", got_data.size(), exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_zero_beat();
        do_start('0);
        collect(10, 0, 0, 0);
        checks++;
        if (done_k !== 2) begin
            errors++;
            $display("FAIL zero_done: done at S+%0d expected S+2", done_k);
        end
        checks++;
        if (valid_cnt !== 0 || rd_cnt !== 0) begin
            errors++;
            $display("FAIL zero_activity: valid cycles=%0d lifo_rd pulses=%0d expected 0/0",
                     valid_cnt, rd_cnt);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) push_word($urandom);
        snap_expect(8);
        do_start('0);
        collect(80, 1, 0, 0);
        checks++;
        if (rd_early !== 4) begin
            errors++;
            $display("FAIL bp_issue: %0d lifo_rd pulses while stalled expected 4", rd_early);
        end
        checks++;
        if (hold_viol !== 0) begin
            errors++;
            $display("FAIL bp_hold: %0d head changes under backpressure expected 0", hold_viol);
        end
        checks++;
        if (got_data.size() !== 8 || done_k < 0) begin
            errors++;
            $display("FAIL bp_count: got %0d beats done_k=%0d expected 8 with done", got_data.size(), done_k);
        end
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h last=%b expected %h last=%b",
                         i, got_data[i], got_last[i], exp_q[i], (i == 7));
            end
        end
        checks++;
        if (rd_empty_cnt !== 0 || words_sent !== LW'(8)) begin
            errors++;
            $display("FAIL bp_end: rd_while_empty=%0d words_sent=%0d expected 0/8", rd_empty_cnt, words_sent);
        end
    endtask

    task automatic test_stall();
        push_word(32'h11);
        push_word(32'h22);
        do_start(LW'(4));
        collect(15, 0, 0, 0);
        checks++;
        if (got_data.size() !== 2 || got_data[0] !== 32'h22 || got_data[1] !== 32'h11) begin
            errors++;
            $display("FAIL stall_first: got %0d beats expected 22,11", got_data.size());
        end
        checks++;
        if (busy !== 1'b1 || done_k !== -1 || rd_empty_cnt !== 0) begin
            errors++;
            $display("FAIL stall_wait: busy=%b done_k=%0d rd_empty=%0d expected 1/-1/0",
                     busy, done_k, rd_empty_cnt);
        end
        push_q.delete();
        push_q.push_back(32'hA);
        push_q.push_back(32'hB);
        collect(30, 0, 0, 1);
        checks++;
        if (got_data.size() !== 2 || got_data[0] !== 32'hB || got_data[1] !== 32'hA
            || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got %0d beats expected B then A(last)", got_data.size());
        end
        checks++;
        if (done_k < 0 || words_sent !== LW'(4) || lifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: done_k=%0d words_sent=%0d empty=%b expected done/4/1",
                     done_k, words_sent, lifo_empty);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 10; i++) push_word($urandom);
        snap_expect(2);
        do_start('0);
        collect(30, 0, 2, 0);
        checks++;
        if (got_data.size() !== 2 || got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL rstmid_pre: got %0d beats expected %h,%h", got_data.size(), exp_q[0], exp_q[1]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, lifo_rd, m_valid, m_last} !== 5'b0 || m_data !== '0 || words_sent !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl=%b m_data=%h words_sent=%0d expected all zero",
                     {busy, done, lifo_rd, m_valid, m_last}, m_data, words_sent);
        end
        n = sp;
        snap_expect(n);
        do_start('0);
        collect(60, 0, 0, 0);
        checks++;
        if (got_data.size() !== n || done_k < 0 || words_sent !== LW'(n)) begin
            errors++;
            $display("FAIL rstmid_count: got %0d beats words_sent=%0d done_k=%0d expected %0d",
                     got_data.size(), words_sent, done_k, n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL rstmid_beat%0d: got %h last=%b expected %h last=%b",
                         i, got_data[i], got_last[i], exp_q[i], (i == n - 1));
            end
        end
    endtask

    task automatic test_random();
        int n, l, take;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) push_word($urandom);
            l = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, n);
            take = (l == 0) ? n : l;
            snap_expect(take);
            do_start(LW'(l));
            collect(300, 2, 0, 0);
            checks++;
            if (got_data.size() !== take || done_k < 0 || hold_viol !== 0) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d beats done_k=%0d hold_viol=%0d expected %0d/done/0",
                         it, got_data.size(), done_k, hold_viol, take);
            end
            for (int i = 0; i < take && i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_q[i] || got_last[i] !== (i == take - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h last=%b expected %h last=%b",
                             it, i, got_data[i], got_last[i], exp_q[i], (i == take - 1));
                end
            end
            checks++;
            if (words_sent !== LW'(take) || lifo_words !== LW'(n - take)) begin
                errors++;
                $display("FAIL rand%0d_end: words_sent=%0d lifo_words=%0d expected %0d/%0d",
                         it, words_sent, lifo_words, take, n - take);
            end
            if (sp > 0) begin
                do_start('0);
                collect(100, 0, 0, 0);
            end
            checks++;
            if (lifo_empty !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_clean: empty=%b busy=%b expected 1/0", it, lifo_empty, busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        len = '0;
        m_ready = 1'b1;
        tick();
        tick();
        test_reset();
        test_drain_all();
        test_len();
        test_zero_beat();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
